// File: rtl/rv_pkg.sv
// Shared integer register-file constants: default geometry, the hardwired-zero
// register index and the address-range helper used by the write and read paths.
package rv_pkg;

    localparam int          XLEN_DEF = 32;
    localparam int          NREG_DEF = 32;
    localparam int          AW_DEF   = 5;
    localparam int unsigned REG_ZERO = 0;

    // True for an address that names real storage: not x0 and inside the file.
    function automatic logic addr_ok(input int unsigned addr, input int unsigned nreg);
        return (addr != REG_ZERO) && (addr < nreg);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port of the register file: address mux, optional write-to-read bypass
// and an optional output register that adds one cycle of latency.
module regfile_rdport
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int AW     = AW_DEF,
    parameter int BYPASS = 1,
    parameter int RD_REG = 0
) (
    input  logic                      clk,
    input  logic                      rstd,
    input  logic [AW-1:0]             ra,
    input  logic [AW-1:0]             wa,
    input  logic [XLEN-1:0]           wr,
    input  logic                      wren,
    input  logic [NREG-1:1][XLEN-1:0] rf,
    input  logic [NREG-1:1]           busy,
    output logic [XLEN-1:0]           rd,
    output logic                      bsy
);

    logic [XLEN-1:0] rd_c;
    logic            bsy_c;

    // x0 and out-of-range addresses read as zero and never busy; the whole
    // port reads zero while reset is held, even if a write is being presented.
    always_comb begin
        rd_c  = '0;
        bsy_c = 1'b0;
        if (rstd && addr_ok(32'(ra), NREG)) begin
            rd_c  = rf[ra];
            bsy_c = busy[ra];
            if ((BYPASS != 0) && wren && (wa == ra)) begin
                rd_c  = wr;
                bsy_c = 1'b0;
            end
        end
    end

    generate
        if (RD_REG != 0) begin : g_reg
            always_ff @(posedge clk or negedge rstd) begin
                if (!rstd) begin
                    rd  <= '0;
                    bsy <= 1'b0;
                end else begin
                    rd  <= rd_c;
                    bsy <= bsy_c;
                end
            end
        end else begin : g_comb
            logic unused_clk;
            assign unused_clk = clk;
            assign rd         = rd_c;
            assign bsy        = bsy_c;
        end
    endgenerate

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with hardwired x0, two read ports, one writeback port and
// a per-register busy scoreboard so decode can stall on RAW hazards.
module regfile_sb
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int AW     = AW_DEF,
    parameter int BYPASS = 1,
    parameter int RD_REG = 0
) (
    input  logic            clk,
    input  logic            rstd,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rr1,
    output logic [XLEN-1:0] rr2,
    output logic            busy1,
    output logic            busy2,
    output logic            hazard,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wr,
    input  logic            wren,
    input  logic            issue,
    input  logic [AW-1:0]   issue_rd
);

    logic [NREG-1:1][XLEN-1:0] rf;
    logic [NREG-1:1]           busy;
    logic                      wr_ok;
    logic                      iss_ok;

    assign wr_ok  = wren  && addr_ok(32'(wa), NREG);
    assign iss_ok = issue && addr_ok(32'(issue_rd), NREG);

    // When writeback and issue hit the same register, the set wins: the newly
    // issued instruction is now the pending producer of that register.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            rf   <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) begin
                rf[wa] <= wr;
            end
            for (int i = 1; i < NREG; i++) begin
                if (iss_ok && (issue_rd == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wr_ok && (wa == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    regfile_rdport #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(BYPASS), .RD_REG(RD_REG)
    ) u_rd1 (
        .clk(clk), .rstd(rstd), .ra(ra1), .wa(wa), .wr(wr), .wren(wren),
        .rf(rf), .busy(busy), .rd(rr1), .bsy(busy1)
    );

    regfile_rdport #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(BYPASS), .RD_REG(RD_REG)
    ) u_rd2 (
        .clk(clk), .rstd(rstd), .ra(ra2), .wa(wa), .wr(wr), .wren(wren),
        .rf(rf), .busy(busy), .rd(rr2), .bsy(busy2)
    );

    // Both busy outputs come from the same timing domain, so hazard is always
    // consistent with them whether reads are registered or not.
    assign hazard = busy1 | busy2;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three configurations share one stimulus stream and are
// checked against a queue of expected values from a reference model and directed constants.
module tb_regfile_sb;

    localparam int A = 0, B = 10, C = 20;
    localparam int RR1 = 0, RR2 = 1, BY1 = 2, BY2 = 3, HZ = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstd;
    logic [4:0]  ra1, ra2, wa, issue_rd;
    logic [31:0] wr;
    logic        wren, issue;

    logic [31:0] a_rr1, a_rr2, b_rr1, b_rr2, c_rr1, c_rr2;
    logic        a_b1, a_b2, a_hz, b_b1, b_b2, b_hz, c_b1, c_b2, c_hz;

    // a: combinational reads with bypass; b: 24 registers, no bypass; c: registered reads
    regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1), .RD_REG(0)) dut_a (
        .clk(clk), .rstd(rstd), .ra1(ra1), .ra2(ra2), .rr1(a_rr1), .rr2(a_rr2),
        .busy1(a_b1), .busy2(a_b2), .hazard(a_hz), .wa(wa), .wr(wr), .wren(wren),
        .issue(issue), .issue_rd(issue_rd));

    regfile_sb #(.XLEN(32), .NREG(24), .AW(5), .BYPASS(0), .RD_REG(0)) dut_b (
        .clk(clk), .rstd(rstd), .ra1(ra1), .ra2(ra2), .rr1(b_rr1), .rr2(b_rr2),
        .busy1(b_b1), .busy2(b_b2), .hazard(b_hz), .wa(wa), .wr(wr), .wren(wren),
        .issue(issue), .issue_rd(issue_rd));

    regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1), .RD_REG(1)) dut_c (
        .clk(clk), .rstd(rstd), .ra1(ra1), .ra2(ra2), .rr1(c_rr1), .rr2(c_rr2),
        .busy1(c_b1), .busy2(c_b2), .hazard(c_hz), .wa(wa), .wr(wr), .wren(wren),
        .issue(issue), .issue_rd(issue_rd));

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t       q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_rf[2][32];
    logic        m_bz[2][32];
    logic [32:0] cur1 = '0, cur2 = '0, prev1 = '0, prev2 = '0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            A + RR1: return a_rr1;
            A + RR2: return a_rr2;
            A + BY1: return {31'd0, a_b1};
            A + BY2: return {31'd0, a_b2};
            A + HZ:  return {31'd0, a_hz};
            B + RR1: return b_rr1;
            B + RR2: return b_rr2;
            B + BY1: return {31'd0, b_b1};
            B + BY2: return {31'd0, b_b2};
            B + HZ:  return {31'd0, b_hz};
            C + RR1: return c_rr1;
            C + RR2: return c_rr2;
            C + BY1: return {31'd0, c_b1};
            C + BY2: return {31'd0, c_b2};
            C + HZ:  return {31'd0, c_hz};
            default: return 'x;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        q.push_back(it);
    endtask

    task automatic drain();
        item_t       it;
        logic [31:0] obs;
        while (q.size() > 0) begin
            it  = q.pop_front();
            obs = observe(it.sel);
            n_tests++;
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    // Reference model of a combinational port: m=0 is config a (32 regs, bypass),
    // m=1 is config b (24 regs, no bypass). Result is {busy, data}.
    function automatic logic [32:0] mread(input int m, input logic [4:0] ra);
        int          n;
        logic [31:0] d;
        logic        bz;
        n = (m == 0) ? 32 : 24;
        if (!rstd || (ra == 5'd0) || (int'(ra) >= n)) return 33'd0;
        d  = m_rf[m][ra];
        bz = m_bz[m][ra];
        if ((m == 0) && wren && (wa == ra)) begin
            d  = wr;
            bz = 1'b0;
        end
        return {bz, d};
    endfunction

    task automatic mclear();
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 32; r++) begin
                m_rf[m][r] = '0;
                m_bz[m][r] = 1'b0;
            end
        end
    endtask

    task automatic mupdate();
        int n;
        if (!rstd) begin
            mclear();
        end else begin
            for (int m = 0; m < 2; m++) begin
                n = (m == 0) ? 32 : 24;
                if (wren && (wa != 5'd0) && (int'(wa) < n)) begin
                    m_rf[m][wa] = wr;
                    m_bz[m][wa] = 1'b0;
                end
                if (issue && (issue_rd != 5'd0) && (int'(issue_rd) < n)) begin
                    m_bz[m][issue_rd] = 1'b1;
                end
            end
        end
    endtask

    // Inputs are already driven (at a falling edge); check, then clock once.
    task automatic step();
        logic [32:0] e1, e2;
        string       p;
        #1;
        for (int m = 0; m < 2; m++) begin
            p  = (m == 0) ? "a" : "b";
            e1 = mread(m, ra1);
            e2 = mread(m, ra2);
            push({p, "_rr1"},   m * 10 + RR1, e1[31:0]);
            push({p, "_rr2"},   m * 10 + RR2, e2[31:0]);
            push({p, "_busy1"}, m * 10 + BY1, {31'd0, e1[32]});
            push({p, "_busy2"}, m * 10 + BY2, {31'd0, e2[32]});
            push({p, "_hazard"}, m * 10 + HZ, {31'd0, e1[32] | e2[32]});
            if (m == 0) begin
                cur1 = e1;
                cur2 = e2;
            end
        end
        if (!rstd) begin
            prev1 = '0;
            prev2 = '0;
        end
        push("c_rr1",    C + RR1, prev1[31:0]);
        push("c_rr2",    C + RR2, prev2[31:0]);
        push("c_busy1",  C + BY1, {31'd0, prev1[32]});
        push("c_busy2",  C + BY2, {31'd0, prev2[32]});
        push("c_hazard", C + HZ,  {31'd0, prev1[32] | prev2[32]});
        drain();
        @(posedge clk);
        prev1 = rstd ? cur1 : 33'd0;
        prev2 = rstd ? cur2 : 33'd0;
        mupdate();
        @(negedge clk);
    endtask

    task automatic idle();
        wren  = 1'b0;
        issue = 1'b0;
    endtask

    initial begin
        rstd = 1'b1; ra1 = 5'd5; ra2 = 5'd31; wa = '0; wr = '0;
        wren = 1'b0; issue = 1'b0; issue_rd = '0;
        mclear();
        #2 rstd = 1'b0;
        mclear();
        push("rst_a_rr1", A + RR1, 32'd0);
        push("rst_c_rr2", C + RR2, 32'd0);
        push("rst_b_hz",  B + HZ,  32'd0);
        step();
        // reset held while a write and issue are presented: nothing shows through
        wren = 1'b1; wa = 5'd5; wr = 32'hFFFF_FFFF; issue = 1'b1; issue_rd = 5'd5;
        push("rst_wr_a_rr1",   A + RR1, 32'd0);
        push("rst_wr_a_busy1", A + BY1, 32'd0);
        step();

        rstd = 1'b1;
        wren = 1'b1; wa = 5'd5; wr = 32'hDEAD_BEEF; issue = 1'b0; ra1 = 5'd5; ra2 = 5'd7;
        push("wr_byp_a_rr1", A + RR1, 32'hDEAD_BEEF);
        push("wr_nobyp_b_rr1", B + RR1, 32'd0);
        step();
        idle();
        push("wr_a_rr1", A + RR1, 32'hDEAD_BEEF);
        push("wr_b_rr1", B + RR1, 32'hDEAD_BEEF);
        push("wr_c_rr1", C + RR1, 32'hDEAD_BEEF);
        step();

        wren = 1'b1; wa = 5'd0; wr = 32'h1; issue = 1'b1; issue_rd = 5'd0; ra1 = 5'd0;
        push("x0_a_rr1", A + RR1, 32'd0);
        step();
        idle();
        push("x0_a_rr1_after",   A + RR1, 32'd0);
        push("x0_a_busy1_after", A + BY1, 32'd0);
        push("x0_b_rr1_after",   B + RR1, 32'd0);
        step();

        issue = 1'b1; issue_rd = 5'd7; ra2 = 5'd7;
        step();
        issue = 1'b0; wren = 1'b1; wa = 5'd7; wr = 32'h1234_5678;
        push("byp_a_rr2",   A + RR2, 32'h1234_5678);
        push("byp_a_busy2", A + BY2, 32'd0);
        push("byp_a_hz",    A + HZ,  32'd0);
        push("nobyp_b_rr2",   B + RR2, 32'd0);
        push("nobyp_b_busy2", B + BY2, 32'd1);
        push("nobyp_b_hz",    B + HZ,  32'd1);
        step();
        idle();
        push("nobyp_b_rr2_after",   B + RR2, 32'h1234_5678);
        push("nobyp_b_busy2_after", B + BY2, 32'd0);
        push("byp_c_rr2", C + RR2, 32'h1234_5678);
        step();

        ra1 = 5'd3; ra2 = 5'd0; issue = 1'b1; issue_rd = 5'd3;
        push("sb_a_busy1_issue", A + BY1, 32'd0);
        step();
        idle();
        push("sb_a_busy1", A + BY1, 32'd1);
        push("sb_a_hz",    A + HZ,  32'd1);
        push("sb_b_busy1", B + BY1, 32'd1);
        step();
        wren = 1'b1; wa = 5'd3; wr = 32'h33;
        push("sb_a_busy1_wb", A + BY1, 32'd0);
        push("sb_b_busy1_wb", B + BY1, 32'd1);
        push("sb_b_hz_wb",    B + HZ,  32'd1);
        step();
        idle();
        push("sb_b_busy1_clr", B + BY1, 32'd0);
        push("sb_a_rr1_clr",   A + RR1, 32'h33);
        step();
        wren = 1'b1; wa = 5'd3; wr = 32'h44; issue = 1'b1; issue_rd = 5'd3;
        push("same_b_rr1", B + RR1, 32'h33);
        step();
        idle();
        push("same_a_rr1",   A + RR1, 32'h44);
        push("same_a_busy1", A + BY1, 32'd1);
        push("same_b_busy1", B + BY1, 32'd1);
        push("same_c_busy1", C + BY1, 32'd0);
        step();
        wren = 1'b1; wa = 5'd3; wr = 32'h45;
        step();

        ra1 = 5'd0; wren = 1'b1; wa = 5'd9; wr = 32'hA5A5_A5A5;
        step();
        idle(); ra1 = 5'd9;
        push("rdreg_a_rr1",      A + RR1, 32'hA5A5_A5A5);
        push("rdreg_c_rr1_early", C + RR1, 32'd0);
        step();
        push("rdreg_c_rr1", C + RR1, 32'hA5A5_A5A5);
        step();

        wren = 1'b1; wa = 5'd30; wr = 32'hBEEF; ra1 = 5'd30;
        issue = 1'b1; issue_rd = 5'd28; ra2 = 5'd28;
        step();
        idle();
        push("oor_a_rr1",   A + RR1, 32'hBEEF);
        push("oor_b_rr1",   B + RR1, 32'd0);
        push("oor_a_busy2", A + BY2, 32'd1);
        push("oor_b_busy2", B + BY2, 32'd0);
        push("oor_b_hz",    B + HZ,  32'd0);
        step();
        wren = 1'b1; wa = 5'd28; wr = 32'h28;
        step();

        for (int i = 0; i < 40; i++) begin
            ra1      = 5'($urandom_range(0, 31));
            ra2      = 5'($urandom_range(0, 31));
            wa       = (i % 3 == 0) ? ra1 : 5'($urandom_range(0, 31));
            wr       = $urandom;
            wren     = 1'($urandom_range(0, 1));
            issue    = 1'($urandom_range(0, 1));
            issue_rd = (i % 4 == 0) ? wa : 5'($urandom_range(0, 31));
            step();
        end

        idle(); ra1 = 5'd4; issue = 1'b1; issue_rd = 5'd4;
        step();
        idle();
        push("pre_rst_a_busy1", A + BY1, 32'd1);
        step();
        rstd = 1'b0; ra1 = 5'd4; ra2 = 5'd9;
        mclear();
        push("mid_rst_a_busy1", A + BY1, 32'd0);
        push("mid_rst_a_rr2",   A + RR2, 32'd0);
        push("mid_rst_c_rr2",   C + RR2, 32'd0);
        push("mid_rst_c_hz",    C + HZ,  32'd0);
        step();
        rstd = 1'b1; ra1 = 5'd9;
        push("post_rst_a_rr1", A + RR1, 32'd0);
        push("post_rst_b_rr1", B + RR1, 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
